// File: rtl/sb_io.sv
// Bidirectional pad cell for a WIDTH-bit bus: optional output data/enable registers,
// optional input register, input hold for latch modes and an optional pull-up.
module sb_io #(
    parameter logic [5:0] PIN_TYPE = 6'b101001,
    parameter logic       PULLUP   = 1'b0,
    parameter int         WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clock_enable,
    input  logic             output_enable,
    input  logic             latch_input_value,
    input  logic [WIDTH-1:0] d_out_0,
    output logic [WIDTH-1:0] d_in_0,
    inout  wire  [WIDTH-1:0] package_pin
);

    localparam logic [3:0] OUT_MODE  = PIN_TYPE[5:2];
    localparam logic [1:0] IN_MODE   = PIN_TYPE[1:0];
    localparam logic [1:0] OE_SEL    = OUT_MODE[3:2];
    localparam logic       DATA_REG  = OUT_MODE[0];
    localparam logic       DATA_INV  = (OUT_MODE[1:0] == 2'b11);
    // DDR codes (low bits 00) and codes with no enable source never drive.
    localparam logic       OUT_VALID = (OUT_MODE[1:0] != 2'b00) && (OE_SEL != 2'b00);

    logic [WIDTH-1:0] data_reg;
    logic             oe_reg;
    logic [WIDTH-1:0] in_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] drive_val;
    logic             drive_en;
    logic [WIDTH-1:0] pad_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            oe_reg   <= 1'b0;
            in_reg   <= '0;
            hold_reg <= '0;
        end else if (clock_enable) begin
            data_reg <= d_out_0;
            oe_reg   <= output_enable;
            if (!(IN_MODE == 2'b10 && latch_input_value))
                in_reg <= pad_val;
            // Tracks the pad while transparent so assertion shows the pre-change value.
            if (!latch_input_value)
                hold_reg <= pad_val;
        end
    end

    always_comb begin
        drive_en = 1'b0;
        case (OE_SEL)
            2'b01:   drive_en = 1'b1;
            2'b10:   drive_en = output_enable;
            2'b11:   drive_en = oe_reg;
            default: drive_en = 1'b0;
        endcase
        drive_en = drive_en & OUT_VALID;
    end

    always_comb begin
        drive_val = d_out_0;
        if (DATA_REG)
            drive_val = DATA_INV ? ~data_reg : data_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pad
            assign package_pin[gi] = drive_en ? drive_val[gi] : 1'bz;
            if (PULLUP) begin : g_pu
                pullup pu_i (package_pin[gi]);
            end
        end
    endgenerate

    assign pad_val = package_pin;

    always_comb begin
        d_in_0 = pad_val;
        case (IN_MODE)
            2'b01:   d_in_0 = pad_val;
            2'b11:   d_in_0 = latch_input_value ? hold_reg : pad_val;
            default: d_in_0 = in_reg;
        endcase
    end

endmodule

// File: tb/tb_sb_io.sv
// Directed bench for sb_io: one instance per pad configuration, each on its own pad net,
// with an external tristate driver on the pads whose inputs are exercised.
module tb_sb_io;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        oe = 1'b0;
    logic        latch = 1'b0;
    logic [15:0] d_out = 16'h0000;
    logic [15:0] ext_val = 16'h0000;
    logic [2:0]  ext_en = 3'b000;   // 0: comb pad, 1: latch-11 pad, 2: latch-10 pad

    int checks = 0;
    int failures = 0;

    wire  [15:0] pad_c, pad_n, pad_r, pad_i, pad_l, pad_rl;
    logic [15:0] din_c, din_n, din_r, din_i, din_l, din_rl;

    assign pad_c  = ext_en[0] ? ext_val : 16'hzzzz;
    assign pad_l  = ext_en[1] ? ext_val : 16'hzzzz;
    assign pad_rl = ext_en[2] ? ext_val : 16'hzzzz;

    always #5 clk = ~clk;

    sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b1), .WIDTH(16)) u_comb (
        .clk(clk), .rst(rst), .clock_enable(ce), .output_enable(oe),
        .latch_input_value(latch), .d_out_0(d_out), .d_in_0(din_c), .package_pin(pad_c));
    sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b0), .WIDTH(16)) u_nopull (
        .clk(clk), .rst(rst), .clock_enable(ce), .output_enable(oe),
        .latch_input_value(latch), .d_out_0(d_out), .d_in_0(din_n), .package_pin(pad_n));
    sb_io #(.PIN_TYPE(6'b110100), .PULLUP(1'b1), .WIDTH(16)) u_reg (
        .clk(clk), .rst(rst), .clock_enable(ce), .output_enable(oe),
        .latch_input_value(latch), .d_out_0(d_out), .d_in_0(din_r), .package_pin(pad_r));
    sb_io #(.PIN_TYPE(6'b011100), .PULLUP(1'b1), .WIDTH(16)) u_inv (
        .clk(clk), .rst(rst), .clock_enable(ce), .output_enable(oe),
        .latch_input_value(latch), .d_out_0(d_out), .d_in_0(din_i), .package_pin(pad_i));
    sb_io #(.PIN_TYPE(6'b000011), .PULLUP(1'b1), .WIDTH(16)) u_lat (
        .clk(clk), .rst(rst), .clock_enable(ce), .output_enable(oe),
        .latch_input_value(latch), .d_out_0(d_out), .d_in_0(din_l), .package_pin(pad_l));
    sb_io #(.PIN_TYPE(6'b000010), .PULLUP(1'b1), .WIDTH(16)) u_rlat (
        .clk(clk), .rst(rst), .clock_enable(ce), .output_enable(oe),
        .latch_input_value(latch), .d_out_0(d_out), .d_in_0(din_rl), .package_pin(pad_rl));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // An undriven net without pull-up is Z in four-state simulators and 0 in two-state ones.
    task automatic check_float(input string tag, input logic [15:0] obs);
        checks++;
        assert (obs === 16'hzzzz || obs === 16'h0000) else begin
            failures++;
            $error("FAIL %s observed=%h expected=zzzz", tag, obs);
        end
        $display("check %-14s observed=%h expected=zzzz", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_reg_pad", pad_r, 16'hFFFF);
        check("rst_reg_din", din_r, 16'h0000);
        check("rst_inv_pad", pad_i, 16'hFFFF);
        rst = 1'b0;

        // Combinational 101001: drive and loopback in the same cycle
        oe = 1'b1;
        d_out = 16'hA5C3;
        #1;
        check("comb_pad", pad_c, 16'hA5C3);
        check("comb_din", din_c, 16'hA5C3);
        check("comb_np_pad", pad_n, 16'hA5C3);
        check("comb_np_din", din_n, 16'hA5C3);
        oe = 1'b0;
        ext_val = 16'h1234;
        ext_en[0] = 1'b1;
        #1;
        check("comb_ext_din", din_c, 16'h1234);
        ext_en[0] = 1'b0;
        #1;
        check("comb_pullup", din_c, 16'hFFFF);
        check_float("comb_nopull", din_n);

        // Registered data/enable and input, 110100
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_out = 16'h00FF;
        oe = 1'b1;
        #1;
        check("reg_pad_pre", pad_r, 16'hFFFF);
        tick();
        check("reg_pad_n", pad_r, 16'h00FF);
        check("reg_din_n", din_r, 16'hFFFF);
        tick();
        check("reg_din_n1", din_r, 16'h00FF);
        rst = 1'b1;
        tick();
        check("reg_rst_pad", pad_r, 16'hFFFF);
        check("reg_rst_din", din_r, 16'h0000);
        rst = 1'b0;

        // Registered inverted data, always enabled, 011100
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("inv_pad_rst", pad_i, 16'hFFFF);
        d_out = 16'h0F0F;
        tick();
        check("inv_pad", pad_i, 16'hF0F0);
        ce = 1'b0;
        d_out = 16'h1111;
        tick();
        check("inv_ce_pad", pad_i, 16'hF0F0);
        check("inv_ce_din", din_i, 16'hFFFF);
        ce = 1'b1;
        tick();
        check("inv_pad2", pad_i, 16'hEEEE);
        check("inv_din2", din_i, 16'hF0F0);

        // Combinational latch mode 000011
        ext_val = 16'hBEEF;
        ext_en[1] = 1'b1;
        latch = 1'b0;
        #1;
        check("lat_transp", din_l, 16'hBEEF);
        tick();
        latch = 1'b1;
        ext_val = 16'h0001;
        #1;
        check("lat_pad", pad_l, 16'h0001);
        check("lat_hold", din_l, 16'hBEEF);
        tick();
        check("lat_hold_clk", din_l, 16'hBEEF);
        latch = 1'b0;
        #1;
        check("lat_release", din_l, 16'h0001);
        ext_en[1] = 1'b0;

        // Registered latch mode 000010
        ext_val = 16'h1357;
        ext_en[2] = 1'b1;
        tick();
        check("rlat_load", din_rl, 16'h1357);
        latch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_val = 16'h2000 + 16'(i * 16'h0111);
            tick();
            check("rlat_hold", din_rl, 16'h1357);
        end
        latch = 1'b0;
        ext_val = 16'hABCD;
        #1;
        check("rlat_pad", pad_rl, 16'hABCD);
        check("rlat_pre", din_rl, 16'h1357);
        tick();
        check("rlat_new", din_rl, 16'hABCD);
        ext_en[2] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
